// File: rtl/can_mac_bit_destuffer.sv
// Receive-side CAN bit destuffer: drops stuff bits after five equal bits,
// forwards destuffed bits to the CRC-15 unit and flags stuff errors.
module can_mac_bit_destuffer #(
    parameter int CNT_W = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SAMPLE_STRB,
    input  logic             SAMPLE_VAL,
    input  logic             DESTUFF_EN,
    input  logic             FRAME_START,
    output logic             BITVAL,
    output logic             BITSTRB,
    output logic             CRC_CLEAR,
    output logic             STUFF_BIT,
    output logic             STUFF_PENDING,
    output logic             STUFF_ERR,
    output logic [CNT_W-1:0] BIT_CNT
);

    localparam logic [2:0] RUN_STUFF = 3'd5;

    logic             last_q, last_d;
    logic [2:0]       run_q, run_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic             bitval_q, bitval_d;
    logic             bitstrb_q, bitstrb_d;
    logic             clr_q, clr_d;
    logic             stuff_q, stuff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        last_d    = last_q;
        run_d     = run_q;
        err_d     = err_q;
        bitval_d  = bitval_q;
        bitstrb_d = 1'b0;
        clr_d     = 1'b0;
        stuff_d   = 1'b0;
        cnt_d     = cnt_q;

        // FRAME_START has priority; a coincident sample is discarded.
        if (FRAME_START) begin
            run_d  = 3'd0;
            err_d  = 1'b0;
            cnt_d  = '0;
            last_d = 1'b1;
            clr_d  = 1'b1;
        end else if (SAMPLE_STRB && !err_q) begin
            if (!DESTUFF_EN) begin
                run_d  = 3'd0;
                last_d = 1'b1;
            end else if (run_q != RUN_STUFF) begin
                bitstrb_d = 1'b1;
                bitval_d  = SAMPLE_VAL;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (SAMPLE_VAL == last_q && run_q != 3'd0) run_d = run_q + 3'd1;
                else                                       run_d = 3'd1;
                last_d = SAMPLE_VAL;
            end else if (SAMPLE_VAL != last_q) begin
                // Dropped stuff bit opens the next run.
                stuff_d = 1'b1;
                run_d   = 3'd1;
                last_d  = SAMPLE_VAL;
            end else begin
                err_d = 1'b1;
            end
        end

        pend_d = (run_d == RUN_STUFF) && !err_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q    <= 1'b1;
            run_q     <= 3'd0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            bitval_q  <= 1'b1;
            bitstrb_q <= 1'b0;
            clr_q     <= 1'b0;
            stuff_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            last_q    <= last_d;
            run_q     <= run_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            bitval_q  <= bitval_d;
            bitstrb_q <= bitstrb_d;
            clr_q     <= clr_d;
            stuff_q   <= stuff_d;
            cnt_q     <= cnt_d;
        end
    end

    assign BITVAL        = bitval_q;
    assign BITSTRB       = bitstrb_q;
    assign CRC_CLEAR     = clr_q;
    assign STUFF_BIT     = stuff_q;
    assign STUFF_PENDING = pend_q;
    assign STUFF_ERR     = err_q;
    assign BIT_CNT       = cnt_q;

endmodule

// File: tb/tb_can_mac_bit_destuffer.sv
// Bench for can_mac_bit_destuffer: directed vector table, reset/saturation
// sequences and random traffic checked against a bit-history reference model.
module tb_can_mac_bit_destuffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       strb, val, en, fs;
    logic       bitval, bitstrb, crc_clear, stuff_bit, pend, err;
    logic [6:0] cnt;
    logic       bitval3, bitstrb3, crc_clear3, stuff_bit3, pend3, err3;
    logic [2:0] cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    can_mac_bit_destuffer #(.CNT_W(7)) dut (
        .CLK(clk), .RST(rst), .SAMPLE_STRB(strb), .SAMPLE_VAL(val),
        .DESTUFF_EN(en), .FRAME_START(fs), .BITVAL(bitval), .BITSTRB(bitstrb),
        .CRC_CLEAR(crc_clear), .STUFF_BIT(stuff_bit), .STUFF_PENDING(pend),
        .STUFF_ERR(err), .BIT_CNT(cnt)
    );

    can_mac_bit_destuffer #(.CNT_W(3)) dut3 (
        .CLK(clk), .RST(rst), .SAMPLE_STRB(strb), .SAMPLE_VAL(val),
        .DESTUFF_EN(en), .FRAME_START(fs), .BITVAL(bitval3), .BITSTRB(bitstrb3),
        .CRC_CLEAR(crc_clear3), .STUFF_BIT(stuff_bit3), .STUFF_PENDING(pend3),
        .STUFF_ERR(err3), .BIT_CNT(cnt3)
    );

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Keeps the raw in-region bits since the last run break; the run length is
    // simply the number of identical bits at the tail of that history.
    logic m_hist[$];
    logic m_err, m_bitval;
    int   m_cnt;
    logic e_bs, e_clr, e_sb, e_pend;

    function automatic int tail_run();
        int n = 0;
        if (m_hist.size() == 0) return 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != m_hist[m_hist.size()-1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_err = 1'b0; m_bitval = 1'b1; m_cnt = 0;
        e_bs = 1'b0; e_clr = 1'b0; e_sb = 1'b0; e_pend = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic s, input logic e, input logic v);
        e_bs = 1'b0; e_clr = 1'b0; e_sb = 1'b0;
        if (f) begin
            m_hist.delete(); m_err = 1'b0; m_cnt = 0; e_clr = 1'b1;
        end else if (s && !m_err) begin
            if (!e) m_hist.delete();
            else if (tail_run() < 5) begin
                e_bs = 1'b1; m_bitval = v; m_cnt++;
                m_hist.push_back(v);
                if (m_hist.size() > 6) void'(m_hist.pop_front());
            end else if (v != m_hist[m_hist.size()-1]) begin
                e_sb = 1'b1; m_hist.delete(); m_hist.push_back(v);
            end else m_err = 1'b1;
        end
        e_pend = (tail_run() == 5) && !m_err;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("bitstrb", 32'(bitstrb), 32'(e_bs));
        chk("bitval", 32'(bitval), 32'(m_bitval));
        chk("crc_clear", 32'(crc_clear), 32'(e_clr));
        chk("stuff_bit", 32'(stuff_bit), 32'(e_sb));
        chk("stuff_pending", 32'(pend), 32'(e_pend));
        chk("stuff_err", 32'(err), 32'(m_err));
        chk("bit_cnt", 32'(cnt), 32'(m_cnt > 127 ? 127 : m_cnt));
        chk("bit_cnt_w3", 32'(cnt3), 32'(m_cnt > 7 ? 7 : m_cnt));
        chk("strb_clr_excl", 32'(bitstrb & crc_clear), 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare 1 ns later.
    task automatic step(input logic f, input logic s, input logic e, input logic v);
        fs = f; strb = s; en = e; val = v;
        @(posedge clk); #1;
        model_step(f, s, e, v);
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic f, s, e, v;
        logic bs, bv, clr, sb, pd, er;
        int   cn;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic f, s, e, v, bs, bv, clr, sb, pd, er, input int cn);
        vec_t r;
        r.f = f; r.s = s; r.e = e; r.v = v; r.bs = bs; r.bv = bv;
        r.clr = clr; r.sb = sb; r.pd = pd; r.er = er; r.cn = cn;
        vt.push_back(r);
    endtask

    initial begin
        logic prev;
        rst = 1'b1; fs = 0; strb = 0; en = 0; val = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // frame start, CRC_CLEAR lasts one cycle; 0,0,0,0,0,1(stuff),1
        add(1,0,0,0, 0,1,1,0,0,0,0);
        add(0,0,0,0, 0,1,0,0,0,0,0);
        for (int k = 1; k <= 5; k++) add(0,1,1,0, 1,0,0,0,(k==5),0,k);
        add(0,1,1,1, 0,0,0,1,0,0,5);
        add(0,1,1,1, 1,1,0,0,0,0,6);
        // stuff bit opens a run: 0x5,1(stuff),1,1,1,1,0(stuff)
        add(1,0,0,0, 0,1,1,0,0,0,0);
        for (int k = 1; k <= 5; k++) add(0,1,1,0, 1,0,0,0,(k==5),0,k);
        add(0,1,1,1, 0,0,0,1,0,0,5);
        for (int k = 6; k <= 9; k++) add(0,1,1,1, 1,1,0,0,(k==9),0,k);
        add(0,1,1,0, 0,1,0,1,0,0,9);
        // six equal bits -> stuff error, later samples ignored
        add(1,0,0,0, 0,1,1,0,0,0,0);
        for (int k = 1; k <= 5; k++) add(0,1,1,1, 1,1,0,0,(k==5),0,k);
        add(0,1,1,1, 0,1,0,0,0,1,5);
        add(0,1,1,0, 0,1,0,0,0,1,5);
        // end of region: 0,1x5, stuff 0 with EN held, then EN=0 sample
        add(1,0,0,0, 0,1,1,0,0,0,0);
        add(0,1,1,0, 1,0,0,0,0,0,1);
        for (int k = 2; k <= 6; k++) add(0,1,1,1, 1,1,0,0,(k==6),0,k);
        add(0,1,1,0, 0,1,0,1,0,0,6);
        add(0,1,0,1, 0,1,0,0,0,0,6);
        // FRAME_START coincident with a sample
        add(1,1,1,0, 0,1,1,0,0,0,0);
        add(0,0,0,0, 0,1,0,0,0,0,0);

        foreach (vt[i]) begin
            step(vt[i].f, vt[i].s, vt[i].e, vt[i].v);
            chk($sformatf("tbl%0d_bitstrb", i), 32'(bitstrb), 32'(vt[i].bs));
            chk($sformatf("tbl%0d_bitval", i), 32'(bitval), 32'(vt[i].bv));
            chk($sformatf("tbl%0d_crc_clear", i), 32'(crc_clear), 32'(vt[i].clr));
            chk($sformatf("tbl%0d_stuff_bit", i), 32'(stuff_bit), 32'(vt[i].sb));
            chk($sformatf("tbl%0d_pending", i), 32'(pend), 32'(vt[i].pd));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(vt[i].er));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(vt[i].cn));
        end

        // asynchronous reset after three bits
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0);
        fs = 0; strb = 0; en = 0; val = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cnt", 32'(cnt), 32'd0);
        chk("async_rst_bitval", 32'(bitval), 32'd1);
        chk("async_rst_bitstrb", 32'(bitstrb), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_model();

        // saturation of the narrow counter: 9 alternating bits
        step(1, 0, 0, 0);
        for (int k = 0; k < 9; k++) step(0, 1, 1, logic'(k % 2));
        chk("sat_cnt_w3", 32'(cnt3), 32'd7);
        chk("sat_cnt_w7", 32'(cnt), 32'd9);

        // random traffic with long runs favoured to exercise stuff slots
        prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic f, s, e, v;
            f = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 75);
            e = (e_pend || $urandom_range(0, 99) < 92);
            v = ($urandom_range(0, 99) < 80) ? prev : ~prev;
            if ($urandom_range(0, 999) < 3) begin
                fs = 0; strb = 0; en = 0; val = 0;
                #2 rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
                check_model();
            end
            step(f, s, e, v);
            if (s) prev = v;
        end

        fs = 0; strb = 0; en = 0; val = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/can_mac_bit_destuffer.md
# can_mac_bit_destuffer

Receive-side bit destuffer for the CAN MAC. It sits between the bit-timing sampler and the CRC-15 unit. It takes one sampled bus bit per sample strobe and removes CAN stuff bits inside the stuffing region. Destuffed bits go to the CRC unit as a value/strobe pair, and the block also flags stuff errors and counts destuffed bits for the frame controller.

## Interface
Parameters:
- CNT_W, 7, width of the destuffed-bit counter BIT_CNT.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SAMPLE_STRB  in  1  one-cycle pulse per nominal bit at the sample point.
- SAMPLE_VAL  in  1  sampled bus level, valid with SAMPLE_STRB; 1 = recessive, 0 = dominant.
- DESTUFF_EN  in  1  stuffing region active (SOF through end of CRC sequence); qualified by SAMPLE_STRB.
- FRAME_START  in  1  one-cycle pulse; starts a new frame and clears per-frame state.
- BITVAL  out  1  destuffed bit value; drives CRC unit BITVAL.
- BITSTRB  out  1  one-cycle pulse, destuffed bit valid; drives CRC unit BITSTRB.
- CRC_CLEAR  out  1  one-cycle pulse; drives CRC unit CLEAR.
- STUFF_BIT  out  1  one-cycle pulse when a stuff bit is dropped.
- STUFF_PENDING  out  1  level; the next sampled bit is a stuff bit.
- STUFF_ERR  out  1  sticky stuff-error flag.
- BIT_CNT  out  CNT_W  number of BITSTRB pulses since the last FRAME_START; saturates at all-ones.

## Operation
- State held: the last bit value (LAST, reset 1) and the run length (RUN, 3 bits, range 0..5, reset 0).
- FRAME_START effects:
  - clears RUN, STUFF_ERR, STUFF_PENDING and BIT_CNT;
  - sets LAST to 1;
  - pulses CRC_CLEAR.
- SAMPLE_STRB with DESTUFF_EN=0: no BITSTRB; RUN cleared; LAST set to 1; STUFF_PENDING cleared.
- SAMPLE_STRB with DESTUFF_EN=1, STUFF_ERR=0 and RUN<5 (normal bit):
  - pulse BITSTRB with BITVAL=SAMPLE_VAL;
  - increment BIT_CNT (saturating);
  - if SAMPLE_VAL==LAST and RUN>0, RUN+=1; otherwise RUN=1;
  - LAST=SAMPLE_VAL.
- SAMPLE_STRB with DESTUFF_EN=1, STUFF_ERR=0 and RUN==5 (stuff slot):
  - if SAMPLE_VAL!=LAST: the bit is dropped; pulse STUFF_BIT; no BITSTRB; RUN=1; LAST=SAMPLE_VAL. The stuff bit counts as the first bit of the new run.
  - if SAMPLE_VAL==LAST: set STUFF_ERR; no BITSTRB; no STUFF_BIT.
- While STUFF_ERR=1, all SAMPLE_STRB are ignored until FRAME_START or RST.
- STUFF_PENDING = (RUN==5) and STUFF_ERR=0, registered.
- The frame controller must hold DESTUFF_EN high while STUFF_PENDING=1. This covers the stuff bit that follows the last CRC bit.
- FRAME_START and SAMPLE_STRB in the same cycle: FRAME_START wins and the sample is discarded.

## Timing
- All outputs are registered.
- Reset values: BITVAL=1; BITSTRB=0; CRC_CLEAR=0; STUFF_BIT=0; STUFF_PENDING=0; STUFF_ERR=0; BIT_CNT=0.
- Latency: for SAMPLE_STRB in cycle T, BITSTRB, STUFF_BIT and STUFF_ERR update in cycle T+1.
  - BITVAL is updated together with BITSTRB and holds its value until the next BITSTRB.
  - BIT_CNT and STUFF_PENDING update in cycle T+1.
- For FRAME_START in cycle T, CRC_CLEAR is high in T+1, and the cleared state is visible in T+1.
- BITSTRB and CRC_CLEAR are never high in the same cycle.
- Back-to-back SAMPLE_STRB (every cycle) are supported at full rate.
- RST mid-frame: all state returns to reset values immediately (asynchronous). Processing restarts at the next FRAME_START or sample.

## Test plan
- Reset → all outputs at their reset values. Then FRAME_START → CRC_CLEAR high one cycle later, for exactly one cycle.
- DESTUFF_EN=1, samples 0,0,0,0,0,1,1 → BITSTRB x5 with BITVAL=0; STUFF_PENDING=1 after the 5th; 6th gives STUFF_BIT pulse and no BITSTRB; 7th gives BITSTRB with BITVAL=1; BIT_CNT=6.
- Stuff bit starts a run: 0,0,0,0,0,1(stuff),1,1,1,1,0 → BITSTRB for 1,1,1,1; the final 0 is dropped with a STUFF_BIT pulse; BIT_CNT=9.
- Six equal bits: 1,1,1,1,1,1 → STUFF_ERR=1 one cycle after the 6th; no BITSTRB for the 6th. Further samples produce nothing until FRAME_START clears STUFF_ERR.
- End of region: last five CRC bits equal → STUFF_PENDING=1 with DESTUFF_EN held; the stuff bit is dropped; then DESTUFF_EN=0 with sample 1 → no BITSTRB, RUN cleared, STUFF_PENDING=0.
- Boundary cases:
  - FRAME_START coincident with SAMPLE_STRB → sample discarded, BIT_CNT=0.
  - RST asserted after 3 bits → BIT_CNT=0 and BITVAL=1 asynchronously.
  - With CNT_W=3 and 9 bits → BIT_CNT saturates at 7.
